// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared mode encodings and index-width helper for the priority arbiter
package arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    // Width needed to hold a one-based index 0..n, where 0 means "no request".
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pe_core.sv
// rtl/pe_core.sv - combinational priority encoder, highest set index wins
module pe_core
    import arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // Ascending scan: the last set bit seen is the highest, so it overrides earlier hits.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                idx       = W'(i + 1);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_priority_arbiter.sv
// rtl/param_priority_arbiter.sv - fixed/round-robin arbiter with a single registered, backpressured result
module param_priority_arbiter
    import arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         mode,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [N-1:0]  masked_req;
    logic [W-1:0]  u_idx;
    logic [N-1:0]  u_onehot;
    logic [W-1:0]  m_idx;
    logic [N-1:0]  m_onehot;
    logic [W-1:0]  win_idx;
    logic [N-1:0]  win_onehot;
    logic [PW-1:0] next_ptr;
    logic          accept;
    logic          rr_sel;

    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;

    // Keep only requesters at or below the pointer; they are first in the descending wrap order.
    always_comb begin
        masked_req = '0;
        for (int i = 0; i < N; i++) begin
            masked_req[i] = req[i] && (PW'(i) <= ptr);
        end
    end

    pe_core #(.N(N)) u_pe_all (
        .in     (req),
        .idx    (u_idx),
        .onehot (u_onehot)
    );

    pe_core #(.N(N)) u_pe_masked (
        .in     (masked_req),
        .idx    (m_idx),
        .onehot (m_onehot)
    );

    assign rr_sel     = (mode == MODE_RR) && (m_idx != '0);
    assign win_idx    = rr_sel ? m_idx : u_idx;
    assign win_onehot = rr_sel ? m_onehot : u_onehot;

    // Next pointer sits just below the zero-based winner (win_idx - 2), wrapping to N-1 after index 0.
    assign next_ptr = (win_idx == W'(1)) ? PW'(N - 1) : PW'(win_idx - W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            ptr          <= PW'(N - 1);
        end else if (accept) begin
            out_valid    <= 1'b1;
            grant_idx    <= win_idx;
            grant_onehot <= win_onehot;
            if ((mode == MODE_RR) && (req != '0)) begin
                ptr <= next_ptr;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb/tb_param_priority_arbiter.sv - self-checking bench with a behavioural arbitration model
module tb_param_priority_arbiter;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         req_valid;
    logic         req_ready;
    logic         mode;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_onehot;
    logic         out_valid;
    logic         out_ready;

    int tests;
    int fails;

    // Reference model state
    bit           m_valid;
    int           m_idx;
    logic [N-1:0] m_onehot;
    int           m_ptr;

    param_priority_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mode         (mode),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner by walking the priority order directly; -1 when nothing requests.
    function automatic int ref_winner(input logic [N-1:0] r, input bit m, input int p);
        if (r == '0) return -1;
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (p - k + N) % N;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_idx    = 0;
        m_onehot = '0;
        m_ptr    = N - 1;
    endtask

    // One clock edge; inputs must already be applied. Returns at edge + 1.
    task automatic step();
        bit acc;
        int g;
        acc = req_valid && (!m_valid || out_ready);
        @(posedge clk);
        #1;
        if (acc) begin
            g        = ref_winner(req, mode, m_ptr);
            m_valid  = 1'b1;
            m_idx    = g + 1;
            m_onehot = (g < 0) ? '0 : (N'(1) << g);
            if (mode && req != '0) m_ptr = (g == 0) ? N - 1 : g - 1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_valid = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++;
        if (grant_idx !== '0) begin fails++; $display("FAIL reset_grant_idx got %0d want 0", grant_idx); end
        tests++;
        if (grant_onehot !== '0) begin fails++; $display("FAIL reset_onehot got %h want 00", grant_onehot); end
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        tests++;
        if (dut.ptr !== 3'd7) begin fails++; $display("FAIL reset_ptr got %0d want 7", dut.ptr); end
        rst_n = 1'b1;
        model_reset();
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_req_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; req_valid = 1'b1; out_ready = 1'b1; req = 8'b1010_0100;
        step();
        tests++;
        if (out_valid !== 1'b1 || grant_idx !== 4'd8 || grant_onehot !== 8'h80) begin
            fails++; $display("FAIL fixed_a4 got v=%0b idx=%0d oh=%h want v=1 idx=8 oh=80", out_valid, grant_idx, grant_onehot);
        end
        req = 8'h05;
        step();
        tests++;
        if (out_valid !== 1'b1 || grant_idx !== 4'd3 || grant_onehot !== 8'h04) begin
            fails++; $display("FAIL fixed_05 got v=%0b idx=%0d oh=%h want v=1 idx=3 oh=04", out_valid, grant_idx, grant_onehot);
        end
    endtask

    task automatic test_empty();
        req = 8'h00; mode = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || grant_idx !== '0 || grant_onehot !== '0) begin
            fails++; $display("FAIL empty got v=%0b idx=%0d oh=%h want v=1 idx=0 oh=00", out_valid, grant_idx, grant_onehot);
        end
        tests++;
        if (dut.ptr !== 3'd7) begin fails++; $display("FAIL empty_ptr got %0d want 7", dut.ptr); end
    endtask

    task automatic test_round_robin();
        int exp_seq [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 8};
        mode = 1'b1; req = 8'hFF; req_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b1 || grant_idx !== W'(exp_seq[i])) begin
                fails++; $display("FAIL rr_step%0d got v=%0b idx=%0d want v=1 idx=%0d", i, out_valid, grant_idx, exp_seq[i]);
            end
        end
        req = 8'h81;
        step();
        tests++;
        if (grant_idx !== 4'd1 || grant_onehot !== 8'h01) begin
            fails++; $display("FAIL rr_81 got idx=%0d oh=%h want idx=1 oh=01", grant_idx, grant_onehot);
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; req = 8'h10; req_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req  = N'($urandom);
            mode = 1'($urandom);
            #1;
            tests++;
            if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d got %0b want 0", i, req_ready); end
            step();
            tests++;
            if (out_valid !== 1'b1 || grant_idx !== 4'd5 || grant_onehot !== 8'h10) begin
                fails++; $display("FAIL bp_hold%0d got v=%0b idx=%0d oh=%h want v=1 idx=5 oh=10", i, out_valid, grant_idx, grant_onehot);
            end
        end
        out_ready = 1'b1; req = 8'h02; mode = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", req_ready); end
        step();
        tests++;
        if (out_valid !== 1'b1 || grant_idx !== 4'd2) begin
            fails++; $display("FAIL bp_pop_load got v=%0b idx=%0d want v=1 idx=2", out_valid, grant_idx);
        end
        req_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got v=%0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; req = 8'h10; req_valid = 1'b1; out_ready = 1'b1;
        step();
        req_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || dut.ptr !== 3'd3) begin
            fails++; $display("FAIL mid_setup got v=%0b ptr=%0d want v=1 ptr=3", out_valid, dut.ptr);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || grant_idx !== '0 || grant_onehot !== '0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL mid_async_clear got v=%0b idx=%0d oh=%h rdy=%0b want 0 0 00 1",
                              out_valid, grant_idx, grant_onehot, req_ready);
        end
        rst_n = 1'b1;
        model_reset();
        mode = 1'b1; req = 8'hFF; req_valid = 1'b1; out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || grant_idx !== 4'd8) begin
            fails++; $display("FAIL mid_after got v=%0b idx=%0d want v=1 idx=8", out_valid, grant_idx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req       = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            mode      = 1'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            tests++;
            if (req_ready !== (!m_valid || out_ready)) begin
                fails++; $display("FAIL rand_ready%0d got %0b want %0b", i, req_ready, (!m_valid || out_ready));
            end
            step();
            tests++;
            if (out_valid !== m_valid) begin
                fails++; $display("FAIL rand_valid%0d got %0b want %0b", i, out_valid, m_valid);
            end else if (m_valid && (grant_idx !== W'(m_idx) || grant_onehot !== m_onehot)) begin
                fails++; $display("FAIL rand_grant%0d got idx=%0d oh=%h want idx=%0d oh=%h",
                                  i, grant_idx, grant_onehot, m_idx, m_onehot);
            end
            tests++;
            if (dut.ptr !== 3'(m_ptr)) begin
                fails++; $display("FAIL rand_ptr%0d got %0d want %0d", i, dut.ptr, m_ptr);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        test_reset();
        test_fixed();
        test_empty();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
